// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular-buffer FIFO; frames leave back-to-back
// with a configurable data width, parity and stop-bit count.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sclk,
    input  logic                          RSTn,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          TX_Pin_Out
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = 4;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_parity;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_bit_end;
    logic                 w_frame_done;

    // Write side handshake: wr_en is a valid with no backpressure wait; the
    // word is taken iff wr_en && !full on the same edge, otherwise it is
    // discarded and overflow pulses in the following cycle.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = wr_en && !w_full;

    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_parity = (PARITY == 1) ? ~^w_head : ^w_head;

    always_ff @(posedge sclk or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_overflow <= wr_en && w_full;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = w_bit_end ? '0 : r_cnt + CW'(1);
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_pop         = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_head;
                    w_parity_next = w_head_parity;
                    w_bit_next    = '0;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == DATA_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_frame_done = 1'b1;
                        w_bit_next   = '0;
                        // Chain straight into the next start bit when data waits.
                        if (!w_empty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_head;
                            w_parity_next = w_head_parity;
                            w_state_next  = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit + BW'(1);
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The pin register is loaded with the level belonging to the next state,
    // so the line changes on the same edge as the state.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge sclk or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
        end
    end

    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_frame_done;
    assign TX_Pin_Out = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame configurations checked cycle by cycle
// against a timeline model of FIFO occupancy and line bits.
module tb_uart_tx_fifo;

    logic       sclk    = 1'b0;
    logic       RSTn    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int         sel     = 0;
    int         cyc     = 0;
    int         n_chk   = 0;
    int         n_fail  = 0;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Configuration of each instance: data bits, parity, stop bits, DIV, depth.
    int c_db[4]    = '{8, 8, 8, 5};
    int c_par[4]   = '{0, 1, 2, 2};
    int c_stop[4]  = '{1, 1, 2, 1};
    int c_div[4]   = '{10, 10, 10, 4};
    int c_depth[4] = '{4, 4, 4, 8};

    logic we0, we1, we2, we3;
    assign we0 = wr_en && (sel == 0);
    assign we1 = wr_en && (sel == 1);
    assign we2 = wr_en && (sel == 2);
    assign we3 = wr_en && (sel == 3);

    logic       tx0, busy0, fd0, ov0, full0, empty0;
    logic       tx1, busy1, fd1, ov1, full1, empty1;
    logic       tx2, busy2, fd2, ov2, full2, empty2;
    logic       tx3, busy3, fd3, ov3, full3, empty3;
    logic [2:0] lvl0, lvl1, lvl2;
    logic [3:0] lvl3;

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .sclk(sclk), .RSTn(RSTn), .wr_en(we0), .wr_data(wr_data),
        .full(full0), .empty(empty0), .level(lvl0), .overflow(ov0),
        .busy(busy0), .frame_done(fd0), .TX_Pin_Out(tx0));

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .sclk(sclk), .RSTn(RSTn), .wr_en(we1), .wr_data(wr_data),
        .full(full1), .empty(empty1), .level(lvl1), .overflow(ov1),
        .busy(busy1), .frame_done(fd1), .TX_Pin_Out(tx1));

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .sclk(sclk), .RSTn(RSTn), .wr_en(we2), .wr_data(wr_data),
        .full(full2), .empty(empty2), .level(lvl2), .overflow(ov2),
        .busy(busy2), .frame_done(fd2), .TX_Pin_Out(tx2));

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(12_500_000), .DATA_BITS(5),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) dut3 (
        .sclk(sclk), .RSTn(RSTn), .wr_en(we3), .wr_data(wr_data[4:0]),
        .full(full3), .empty(empty3), .level(lvl3), .overflow(ov3),
        .busy(busy3), .frame_done(fd3), .TX_Pin_Out(tx3));

    // Packed view: {tx, busy, frame_done, overflow, full, empty, level[5:0]}
    logic [11:0] obs;
    always_comb begin
        obs = 12'h000;
        case (sel)
            0: obs = {tx0, busy0, fd0, ov0, full0, empty0, 3'b000, lvl0};
            1: obs = {tx1, busy1, fd1, ov1, full1, empty1, 3'b000, lvl1};
            2: obs = {tx2, busy2, fd2, ov2, full2, empty2, 3'b000, lvl2};
            default: obs = {tx3, busy3, fd3, ov3, full3, empty3, 2'b00, lvl3};
        endcase
    end

    // Model: edges of accepted writes, frame start edges and words, rejected edges.
    int         acc_edge[$];
    int         f_start[$];
    logic [7:0] f_word[$];
    int         rej_edge[$];

    function automatic void model_clear();
        acc_edge.delete();
        f_start.delete();
        f_word.delete();
        rej_edge.delete();
    endfunction

    function automatic int frame_len();
        return (1 + c_db[sel] + ((c_par[sel] != 0) ? 1 : 0) + c_stop[sel]) * c_div[sel];
    endfunction

    function automatic logic frame_bit(logic [7:0] w, int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < c_db[sel]; i++) ones += int'(w[i]);
        if (idx == 0) return 1'b0;
        if (idx <= c_db[sel]) return w[idx-1];
        if (c_par[sel] != 0 && idx == c_db[sel] + 1)
            return (c_par[sel] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    function automatic void model_write(int e, logic [7:0] d);
        int         occ;
        int         start;
        logic [7:0] mask;
        occ  = 0;
        mask = 8'hFF >> (8 - c_db[sel]);
        foreach (acc_edge[i]) if (acc_edge[i] < e) occ++;
        foreach (f_start[i])  if (f_start[i] < e) occ--;
        if (occ < c_depth[sel]) begin
            acc_edge.push_back(e);
            start = e + 1;
            if (f_start.size() > 0 && f_start[$] + frame_len() > start)
                start = f_start[$] + frame_len();
            f_start.push_back(start);
            f_word.push_back(d & mask);
        end else begin
            rej_edge.push_back(e);
        end
    endfunction

    function automatic int model_end();
        if (f_start.size() == 0) return cyc;
        return f_start[$] + frame_len();
    endfunction

    function automatic logic [11:0] exp_at(int k);
        logic tx, bsy, fd, ov;
        int   lvl, len;
        tx = 1'b1; bsy = 1'b0; fd = 1'b0; ov = 1'b0; lvl = 0;
        len = frame_len();
        foreach (f_start[i]) begin
            if (k >= f_start[i] && k < f_start[i] + len) begin
                bsy = 1'b1;
                tx  = frame_bit(f_word[i], (k - f_start[i]) / c_div[sel]);
                if (k == f_start[i] + len - 1) fd = 1'b1;
            end
        end
        foreach (rej_edge[i]) if (rej_edge[i] == k) ov = 1'b1;
        foreach (acc_edge[i]) if (acc_edge[i] <= k) lvl++;
        foreach (f_start[i])  if (f_start[i] <= k) lvl--;
        return {tx, bsy, fd, ov, (lvl == c_depth[sel]), (lvl == 0), 6'(lvl)};
    endfunction

    // Driver: inputs set after the falling edge are sampled on the next rising edge.
    task automatic drive(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        if (we) model_write(cyc + 1, d);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            n_chk++;
            if (obs !== 12'h840) begin
                n_fail++;
                $display("FAIL reset_values inst=%0d got=%h exp=%h", s, obs, 12'h840);
            end
        end
    endtask

    task automatic test_single();
        int fd_cnt, first_low, wr_e;
        fd_cnt = 0; first_low = -1; wr_e = 0;
        sel = 0;
        model_clear();
        for (int i = 0; i < 120; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[9]) fd_cnt++;
            if (!obs[11] && first_low < 0) first_low = cyc;
            if (i == 2) begin
                wr_e = cyc + 1;
                drive(1'b1, 8'h55);
            end else begin
                drive(1'b0, 8'h00);
            end
        end
        n_chk++;
        if (fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_done_count got=%0d exp=1", fd_cnt);
        end
        n_chk++;
        if (first_low !== wr_e + 1) begin
            n_fail++;
            $display("FAIL single_tx_fall got=%0d exp=%0d", first_low, wr_e + 1);
        end
        n_chk++;
        if (obs[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_end got=%b exp=0", obs[10]);
        end
    endtask

    task automatic test_parity();
        for (int s = 1; s <= 2; s++) begin
            int busy_cnt, par_at, wr_e;
            logic par_seen;
            logic [7:0] word;
            busy_cnt = 0; par_seen = 1'bx; wr_e = 0;
            word = (s == 1) ? 8'h55 : 8'h07;
            sel = s;
            model_clear();
            par_at = -1;
            for (int i = 0; i < 140; i++) begin
                @(negedge sclk);
                n_chk++;
                if (obs !== exp_at(cyc)) begin
                    n_fail++;
                    $display("FAIL parity inst=%0d cyc=%0d got=%h exp=%h", s, cyc, obs, exp_at(cyc));
                end
                if (obs[10]) busy_cnt++;
                if (cyc == par_at) par_seen = obs[11];
                if (i == 1) begin
                    wr_e   = cyc + 1;
                    par_at = wr_e + 1 + 90 + 5;
                    drive(1'b1, word);
                end else begin
                    drive(1'b0, 8'h00);
                end
            end
            n_chk++;
            if (busy_cnt !== ((s == 1) ? 110 : 120)) begin
                n_fail++;
                $display("FAIL parity_frame_len inst=%0d got=%0d exp=%0d", s, busy_cnt, (s == 1) ? 110 : 120);
            end
            n_chk++;
            if (par_seen !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_bit inst=%0d got=%b exp=1", s, par_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fd_cnt, busy_cnt, last_fd, bad_gap;
        fd_cnt = 0; busy_cnt = 0; last_fd = -1; bad_gap = 0;
        sel = 0;
        model_clear();
        for (int i = 0; i < 330; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[10]) busy_cnt++;
            if (obs[9]) begin
                fd_cnt++;
                if (last_fd >= 0 && cyc - last_fd != 100) bad_gap++;
                last_fd = cyc;
            end
            if (i >= 1 && i <= 3) drive(1'b1, 8'(i));
            else                  drive(1'b0, 8'h00);
        end
        n_chk++;
        if (fd_cnt !== 3) begin
            n_fail++;
            $display("FAIL b2b_done_count got=%0d exp=3", fd_cnt);
        end
        n_chk++;
        if (busy_cnt !== 300 || bad_gap !== 0) begin
            n_fail++;
            $display("FAIL b2b_no_gap busy=%0d gaps=%0d exp busy=300 gaps=0", busy_cnt, bad_gap);
        end
    endtask

    task automatic test_overflow();
        int ov_cnt, fd_cnt;
        logic full_seen;
        ov_cnt = 0; fd_cnt = 0; full_seen = 1'b0;
        sel = 0;
        model_clear();
        for (int i = 0; i < 530; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[8]) ov_cnt++;
            if (obs[9]) fd_cnt++;
            if (obs[7]) full_seen = 1'b1;
            if (i == 1)                drive(1'b1, 8'h11);
            else if (i >= 5 && i <= 10) drive(1'b1, 8'hA0 + 8'(i));
            else                       drive(1'b0, 8'h00);
        end
        n_chk++;
        if (ov_cnt !== 2) begin
            n_fail++;
            $display("FAIL overflow_pulses got=%0d exp=2", ov_cnt);
        end
        n_chk++;
        if (fd_cnt !== 5 || full_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_frames frames=%0d full=%b exp frames=5 full=1", fd_cnt, full_seen);
        end
    endtask

    task automatic test_wrap();
        int written, fd_cnt, stop_at;
        written = 0; fd_cnt = 0;
        sel = 3;
        model_clear();
        stop_at = cyc + 1500;
        while (cyc < stop_at) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[9]) fd_cnt++;
            if (written < 24 && exp_at(cyc)[5:0] < 6'd2 && $urandom_range(0, 1) == 0) begin
                written++;
                drive(1'b1, 8'($urandom_range(0, 255)));
            end else begin
                drive(1'b0, 8'h00);
            end
            if (written == 24 && cyc > model_end() + 3) break;
        end
        n_chk++;
        if (written !== 24 || fd_cnt !== 24) begin
            n_fail++;
            $display("FAIL wrap_frames written=%0d frames=%0d exp=24", written, fd_cnt);
        end
    endtask

    task automatic test_random();
        int ov_cnt, stop_at;
        ov_cnt = 0;
        sel = 3;
        model_clear();
        stop_at = cyc + 1000;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[8]) ov_cnt++;
            if ($urandom_range(0, 2) == 0) drive(1'b1, 8'($urandom_range(0, 255)));
            else                           drive(1'b0, 8'h00);
        end
        while (cyc <= model_end() + 3 && cyc < stop_at) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[8]) ov_cnt++;
            drive(1'b0, 8'h00);
        end
        n_chk++;
        if (ov_cnt !== rej_edge.size()) begin
            n_fail++;
            $display("FAIL random_overflow_count got=%0d exp=%0d", ov_cnt, rej_edge.size());
        end
    endtask

    task automatic test_reset_mid();
        int tgt, fd_cnt;
        logic reached;
        tgt = -1; fd_cnt = 0; reached = 1'b0;
        sel = 0;
        model_clear();
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (cyc == tgt) begin
                reached = 1'b1;
                break;
            end
            if (i == 1) begin
                drive(1'b1, 8'h00);
                tgt = f_start[0] + 44;
            end else if (i == 2) begin
                drive(1'b1, 8'h3C);
            end else begin
                drive(1'b0, 8'h00);
            end
        end
        n_chk++;
        if (reached !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reach got=%b exp=1", reached);
        end
        wr_en = 1'b0;
        RSTn  = 1'b0;
        #1;
        n_chk++;
        if (obs !== 12'h840) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs, 12'h840);
        end
        repeat (2) @(negedge sclk);
        model_clear();
        RSTn = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(negedge sclk);
            n_chk++;
            if (obs !== exp_at(cyc)) begin
                n_fail++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, obs, exp_at(cyc));
            end
            if (obs[9]) fd_cnt++;
            if (i == 1) drive(1'b1, 8'hA5);
            else        drive(1'b0, 8'h00);
        end
        n_chk++;
        if (fd_cnt !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_frames got=%0d exp=1", fd_cnt);
        end
    endtask

    initial begin
        RSTn  = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge sclk);
        test_reset();
        @(negedge sclk);
        RSTn = 1'b1;
        model_clear();
        test_single();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It is the successor to the single-shot byte sender. Upstream logic pushes words at clock rate, and the block serialises them back-to-back onto the TX pin. Frame format is configurable: data bits, parity and stop bits. The block sits between the system-clock domain logic and the board UART pin driving the MCU.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, sclk frequency in Hz
- BAUD, 115200, line rate; DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit, DIV ≥ 4 required
- DATA_BITS, 8, data bits per frame, legal 5–8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, entries, power of two, ≥ 2

Ports:
- sclk  in  1  system clock, all logic on rising edge
- RSTn  in  1  asynchronous active-low reset
- wr_en  in  1  push wr_data into FIFO this cycle
- wr_data  in  DATA_BITS  word to send, bit 0 transmitted first
- full  out  1  FIFO holds FIFO_DEPTH words
- empty  out  1  FIFO holds 0 words
- level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  one-cycle pulse when wr_en is dropped because full
- busy  out  1  high while a frame is on the line
- frame_done  out  1  one-cycle pulse at end of each frame's last stop bit
- TX_Pin_Out  out  1  serial line, idle high

## Operation
- FIFO: circular buffer with pointers of width clog2(FIFO_DEPTH)+1. Pointers wrap naturally.
  - full means the pointers differ only in MSB; empty means the pointers are equal.
  - A write is accepted iff wr_en && !full, evaluated on the pre-edge full value. A write while full is dropped and pulses overflow, even if a pop occurs in the same cycle.
  - Simultaneous write and pop when not full and not empty: level is unchanged.
  - A write to an empty FIFO while the FSM is idle is legal.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX high. If !empty, pop the head word into a shift register and go to START.
  - START: TX = 0 for DIV cycles, then go to DATA.
  - DATA: TX = shift[0] for DIV cycles per bit, shifting right. After DATA_BITS bits, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: TX = ^data for even parity, ~^data for odd parity, computed over the DATA_BITS bits of the popped word. Lasts DIV cycles.
  - STOP: TX = 1 for STOP_BITS × DIV cycles. At the final cycle, pulse frame_done. If !empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..DIV-1 and is reset on every state entry. A bit boundary occurs when the count reaches DIV-1.
- busy = (state != IDLE).
- Reset, including mid-frame: pointers, level, FSM and counters are cleared. Outputs take these values:
  - TX_Pin_Out = 1, empty = 1, full = 0, level = 0
  - busy = 0, overflow = 0, frame_done = 0
  - Any partial frame is abandoned, and the line goes high immediately (asynchronously).
- TX_Pin_Out is driven from a register, with no combinational path to the pin.

## Timing
- wr_en sampled at edge E0 into an empty, idle block: empty falls after E0. The FSM pops at E1, and TX_Pin_Out falls at E1.
- Start-bit low lasts exactly DIV cycles (E1..E1+DIV).
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV cycles.
- frame_done is high in the last cycle of the frame.
- Back-to-back frames: the next start bit begins the cycle after frame_done, so the line holds no idle cycles.
- level/full/empty update one edge after the accepted write or pop.
- overflow is asserted in the cycle following the rejected wr_en edge, for one cycle.

## Test plan
- Single frame: CLK_FREQ=50M, BAUD=5M (DIV=10), 8N1, write 0x55 -> 100 cycles on the line.
  - Line sequence: 0, 1,0,1,0,1,0,1,0, 1, each bit 10 cycles wide; TX falls one edge after the write.
  - frame_done pulses once; busy drops to 0 after the stop bit.
- Parity: 8O1, write 0x55 -> parity bit 1. 8E2, write 0x07 -> parity bit 1 followed by 2 stop bits (20 cycles high); the frame is 120 cycles.
- Burst/back-to-back: write 0x01,0x02,0x03 on consecutive cycles -> three frames with no idle gap between them.
  - level goes 1,2,3 and then decrements at each pop.
  - Exactly three frame_done pulses, spaced by the frame length.
- Full/overflow: FIFO_DEPTH=4, hold the line busy, write 6 words -> full after the 4th accepted word.
  - The 5th and 6th writes each pulse overflow.
  - Exactly 4 frames are transmitted, carrying the first 4 values.
- Wrap-around: stream 3×FIFO_DEPTH words while keeping level at 1–2 -> all words are transmitted in order and the pointers wrap cleanly.
- Reset mid-frame: assert RSTn low during DATA bit 3 -> TX_Pin_Out goes high within the same cycle, and level, busy and empty take their reset values.
  - After release, a new write of 0xA5 transmits correctly, with no residue of the old frame.
